// File: rtl/sprite_row_drawer.sv
// Sprite row drawer: fetches one sprite row from ROM, applies h/v mirroring, and emits
// clipped, transparency-masked column writes into a scanline buffer at one pixel per clock.
module sprite_row_drawer #(
    parameter int unsigned SPR_W      = 16,
    parameter int unsigned SPR_H      = 16,
    parameter int unsigned FRAME_BITS = 8,
    parameter int unsigned ROM_LAT    = 1,
    parameter int unsigned COL_W      = 10,
    parameter int unsigned SCREEN_W   = 640
) (
    input  logic                                                    clk,
    input  logic                                                    reset,
    input  logic                                                    start,
    input  logic signed [COL_W:0]                                   col_base,
    input  logic                                                    hflip,
    input  logic                                                    vflip,
    input  logic [FRAME_BITS-1:0]                                   frame_id,
    input  logic [$clog2(SPR_H)-1:0]                                row_off,
    output logic [FRAME_BITS+$clog2(SPR_H)+$clog2(SPR_W)-1:0]       rom_addr,
    input  logic [15:0]                                             rom_q,
    output logic [COL_W-1:0]                                        pixel_col,
    output logic [15:0]                                             pixel_data,
    output logic                                                    wren,
    output logic                                                    busy,
    output logic                                                    done
);

    localparam int unsigned XW  = $clog2(SPR_W);
    localparam int unsigned YW  = $clog2(SPR_H);
    localparam int unsigned XSW = COL_W + 2;

    localparam logic [XW-1:0]         IdxLast   = XW'(SPR_W - 1);
    localparam logic signed [XSW-1:0] ScreenLim = XSW'(SCREEN_W);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

    state_e state_q, state_d;

    logic                  accept;
    logic [XW-1:0]         idx_q, idx_d;
    logic [FRAME_BITS-1:0] frame_q;
    logic [YW-1:0]         row_q;
    logic [YW-1:0]         row_eff;
    logic signed [COL_W:0] base_q;
    logic                  hflip_q;

    logic [ROM_LAT-1:0]    vld_q;
    logic [XW-1:0]         tag_q [ROM_LAT];

    logic                  slot_vld;
    logic [XW-1:0]         slot_idx;
    logic [XW-1:0]         slot_ofs;
    logic signed [XSW-1:0] slot_x;
    logic                  on_screen;

    logic                  wren_q, wren_d;
    logic                  last_q, last_d;
    logic [COL_W-1:0]      col_q;
    logic [15:0]           data_q;

    // SPR_H is a power of two, so bitwise inversion gives SPR_H-1-row_off.
    assign row_eff = vflip ? ~row_off : row_off;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        accept  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    accept  = 1'b1;
                    idx_d   = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                // Terminal count stops the counter so the address never spills into the next frame.
                if (idx_q == IdxLast) begin
                    state_d = StDrain;
                end else begin
                    idx_d = idx_q + XW'(1);
                end
            end
            StDrain: begin
                if (last_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pixel slot: the tag that has travelled alongside the ROM read latency.
    assign slot_vld  = vld_q[ROM_LAT-1];
    assign slot_idx  = tag_q[ROM_LAT-1];
    assign slot_ofs  = hflip_q ? ~slot_idx : slot_idx;
    assign slot_x    = $signed({base_q[COL_W], base_q}) + $signed({{(XSW - XW){1'b0}}, slot_ofs});
    assign on_screen = !slot_x[XSW-1] && (slot_x < ScreenLim);

    always_comb begin
        wren_d = slot_vld && !rom_q[15] && on_screen;
        last_d = slot_vld && (slot_idx == IdxLast);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            frame_q <= '0;
            row_q   <= '0;
            base_q  <= '0;
            hflip_q <= 1'b0;
            vld_q   <= '0;
            for (int k = 0; k < ROM_LAT; k++) begin
                tag_q[k] <= '0;
            end
            wren_q  <= 1'b0;
            last_q  <= 1'b0;
            col_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept) begin
                frame_q <= frame_id;
                row_q   <= row_eff;
                base_q  <= col_base;
                hflip_q <= hflip;
            end
            vld_q[0] <= (state_q == StFetch);
            tag_q[0] <= idx_q;
            for (int k = 1; k < ROM_LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                tag_q[k] <= tag_q[k-1];
            end
            wren_q <= wren_d;
            last_q <= last_d;
            // Column and data track every valid slot, masked or not.
            if (slot_vld) begin
                col_q  <= slot_x[COL_W-1:0];
                data_q <= rom_q;
            end
        end
    end

    assign rom_addr   = {frame_q, row_q, idx_q};
    assign pixel_col  = col_q;
    assign pixel_data = data_q;
    assign wren       = wren_q;
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StIdle);

endmodule

// File: tb/tb_sprite_row_drawer.sv
// Randomised self-checking bench for sprite_row_drawer against a per-row expected-write model,
// plus a timing check on a second instance with a wider sprite and longer ROM latency.
module tb_sprite_row_drawer;

    localparam int SPR_W      = 16;
    localparam int SPR_H      = 16;
    localparam int FRAME_BITS = 8;
    localparam int ROM_LAT    = 1;
    localparam int COL_W      = 10;
    localparam int SCREEN_W   = 640;
    localparam int XW         = 4;
    localparam int YW         = 4;
    localparam int AW         = FRAME_BITS + YW + XW;
    localparam int CBW        = COL_W + 1;
    localparam int PERIOD     = SPR_W + ROM_LAT + 2;

    localparam int SPR_W2   = 32;
    localparam int SPR_H2   = 8;
    localparam int ROM_LAT2 = 2;
    localparam int YW2      = 3;
    localparam int AW2      = FRAME_BITS + 3 + 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset, start, hflip, vflip;
    logic signed [COL_W:0] col_base;
    logic [FRAME_BITS-1:0] frame_id;
    logic [YW-1:0]         row_off;
    logic [AW-1:0]         rom_addr;
    logic [15:0]           rom_q;
    logic [COL_W-1:0]      pixel_col;
    logic [15:0]           pixel_data;
    logic                  wren, busy, done;

    logic                  start2;
    logic signed [COL_W:0] col_base2;
    logic [FRAME_BITS-1:0] frame_id2;
    logic [YW2-1:0]        row_off2;
    logic [AW2-1:0]        rom_addr2;
    logic [15:0]           rom_q2;
    logic [COL_W-1:0]      pixel_col2;
    logic [15:0]           pixel_data2;
    logic                  wren2, busy2, done2;

    int checks = 0;
    int errors = 0;
    int rom_mode;
    logic [15:0] rom_mem [0:(1<<AW)-1];
    logic [15:0] rom_pipe [ROM_LAT];
    logic [15:0] rom2_p0, rom2_p1;

    sprite_row_drawer #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .FRAME_BITS(FRAME_BITS),
        .ROM_LAT(ROM_LAT), .COL_W(COL_W), .SCREEN_W(SCREEN_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .col_base(col_base),
        .hflip(hflip), .vflip(vflip), .frame_id(frame_id), .row_off(row_off),
        .rom_addr(rom_addr), .rom_q(rom_q), .pixel_col(pixel_col),
        .pixel_data(pixel_data), .wren(wren), .busy(busy), .done(done)
    );

    sprite_row_drawer #(
        .SPR_W(SPR_W2), .SPR_H(SPR_H2), .FRAME_BITS(FRAME_BITS),
        .ROM_LAT(ROM_LAT2), .COL_W(COL_W), .SCREEN_W(SCREEN_W)
    ) dut2 (
        .clk(clk), .reset(reset), .start(start2), .col_base(col_base2),
        .hflip(1'b0), .vflip(1'b0), .frame_id(frame_id2), .row_off(row_off2),
        .rom_addr(rom_addr2), .rom_q(rom_q2), .pixel_col(pixel_col2),
        .pixel_data(pixel_data2), .wren(wren2), .busy(busy2), .done(done2)
    );

    function automatic logic [15:0] rom_word(input logic [AW-1:0] a);
        case (rom_mode)
            0:       return 16'(a);
            1:       return a[0] ? (16'h8000 | 16'(a)) : 16'(a);
            default: return rom_mem[a];
        endcase
    endfunction

    always @(posedge clk) begin
        rom_pipe[0] <= rom_word(rom_addr);
        for (int k = 1; k < ROM_LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
        rom2_p0 <= 16'(rom_addr2);
        rom2_p1 <= rom2_p0;
    end
    assign rom_q  = rom_pipe[ROM_LAT-1];
    assign rom_q2 = rom2_p1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    task automatic scramble_inputs();
        col_base = CBW'($urandom);
        hflip    = 1'($urandom);
        vflip    = 1'($urandom);
        frame_id = FRAME_BITS'($urandom);
        row_off  = YW'($urandom);
    endtask

    // Draws one row starting in the current cycle (cycle 0); returns in cycle PERIOD,
    // or in the cycle after reset when reset_at >= 0.
    task automatic run_row(input int cb, input bit hf, input bit vf, input int fr, input int row,
                           input int extra_at, input int reset_at, output int strobes);
        logic [AW-1:0] e_addr [SPR_W];
        logic [15:0]   e_data [SPR_W];
        int            e_col  [SPR_W];
        bit            e_wr   [SPR_W];
        int            er, x, idx;
        er = vf ? SPR_H - 1 - row : row;
        for (int i = 0; i < SPR_W; i++) begin
            e_addr[i] = AW'(fr * SPR_W * SPR_H + er * SPR_W + i);
            e_data[i] = rom_word(e_addr[i]);
            x         = cb + (hf ? SPR_W - 1 - i : i);
            e_col[i]  = x & ((1 << COL_W) - 1);
            e_wr[i]   = !e_data[i][15] && x >= 0 && x < SCREEN_W;
        end
        strobes  = 0;
        reset    = 1'b0;
        start    = 1'b1;
        col_base = CBW'(cb);
        hflip    = hf;
        vflip    = vf;
        frame_id = FRAME_BITS'(fr);
        row_off  = YW'(row);
        for (int c = 0; c < PERIOD; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check("done_at_start", 32'(done), 32'd1);
                check("busy_at_start", 32'(busy), 32'd0);
            end else begin
                check("busy_in_row", 32'(busy), 32'd1);
                check("done_in_row", 32'(done), 32'd0);
            end
            if (c >= 1 && c <= SPR_W) check("rom_addr", 32'(rom_addr), 32'(e_addr[c-1]));
            idx = c - ROM_LAT - 2;
            if (idx >= 0 && idx < SPR_W) begin
                check("wren", 32'(wren), 32'(e_wr[idx]));
                check("pixel_col", 32'(pixel_col), 32'(e_col[idx]));
                check("pixel_data", 32'(pixel_data), 32'(e_data[idx]));
            end else begin
                check("wren_outside_slots", 32'(wren), 32'd0);
            end
            if (wren === 1'b1) strobes++;
            @(posedge clk);
            #1;
            scramble_inputs();
            start = (c + 1 == extra_at);
            reset = (c + 1 == reset_at);
            if (reset_at >= 0 && c == reset_at) return;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("idle_done", 32'(done), 32'd1);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_wren", 32'(wren), 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n, cb, extra, first, last, cnt, drise;
        reset    = 1'b1;
        start    = 1'b0;
        start2   = 1'b0;
        col_base2 = '0;
        frame_id2 = '0;
        row_off2  = '0;
        rom_mode = 0;
        scramble_inputs();
        for (int a = 0; a < (1 << AW); a++) begin
            rom_mem[a] = 16'($urandom);
            rom_mem[a][15] = ($urandom_range(0, 3) == 0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_done", 32'(done), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wren", 32'(wren), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_pixel_col", 32'(pixel_col), 32'd0);
        check("rst_pixel_data", 32'(pixel_data), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        // Directed rows: plain, both flips, clipping, transparency.
        run_row(100, 0, 0, 3, 2, -1, -1, n);
        check("plain_strobes", 32'(n), 32'd16);
        idle(1);
        run_row(100, 1, 1, 3, 2, -1, -1, n);
        check("flip_strobes", 32'(n), 32'd16);
        idle(1);
        run_row(-5, 0, 0, 3, 2, -1, -1, n);
        check("clip_left_strobes", 32'(n), 32'd11);
        idle(1);
        run_row(630, 0, 0, 3, 2, -1, -1, n);
        check("clip_right_strobes", 32'(n), 32'd10);
        idle(1);
        run_row(700, 0, 0, 3, 2, -1, -1, n);
        check("offscreen_strobes", 32'(n), 32'd0);
        idle(1);
        rom_mode = 1;
        run_row(200, 0, 0, 3, 2, -1, -1, n);
        check("transparent_strobes", 32'(n), 32'd8);
        idle(1);

        // Handshake: ignored mid-row start, back-to-back row, reset mid-row then immediate start.
        rom_mode = 0;
        run_row(100, 0, 0, 3, 2, 5, -1, n);
        check("ignored_start_strobes", 32'(n), 32'd16);
        run_row(40, 1, 0, 7, 9, -1, -1, n);
        check("back_to_back_strobes", 32'(n), 32'd16);
        idle(1);
        run_row(300, 0, 0, 1, 1, -1, 10, n);
        run_row(20, 0, 1, 2, 5, -1, -1, n);
        check("after_reset_strobes", 32'(n), 32'd16);
        idle(1);

        rom_mode = 2;
        for (int t = 0; t < 40; t++) begin
            cb    = int'($urandom_range(0, 760)) - 60;
            extra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, PERIOD - 1)) : -1;
            run_row(cb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, SPR_H - 1)), extra, -1, n);
            idle(int'($urandom_range(0, 2)));
        end

        // Wider sprite, deeper ROM pipeline.
        start2    = 1'b1;
        col_base2 = CBW'(50);
        frame_id2 = FRAME_BITS'(5);
        row_off2  = YW2'(6);
        first = -1;
        last  = -1;
        cnt   = 0;
        drise = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (wren2 === 1'b1) begin
                if (first < 0) first = c;
                last = c;
                cnt++;
                check("p2_data", 32'(pixel_data2), 32'(5 * SPR_W2 * SPR_H2 + 6 * SPR_W2 + c - (ROM_LAT2 + 2)));
                check("p2_col", 32'(pixel_col2), 32'(50 + c - (ROM_LAT2 + 2)));
            end
            if (c >= 1 && drise < 0 && done2 === 1'b1) drise = c;
            @(posedge clk);
            #1;
            start2 = 1'b0;
        end
        check("p2_first_strobe", 32'(first), 32'(ROM_LAT2 + 2));
        check("p2_last_strobe", 32'(last), 32'(SPR_W2 + ROM_LAT2 + 1));
        check("p2_strobe_count", 32'(cnt), 32'(SPR_W2));
        check("p2_done_rise", 32'(drise), 32'(SPR_W2 + ROM_LAT2 + 2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
